// File: rtl/char_pattern_gen.sv
// char_pattern_gen
//   Stimulus generator for energy characterisation of datapath blocks.
//   Emits NUM_PKTS packets of PAYLOAD flits, with GAP idle cycles after each
//   packet. Each DATA_W-bit flit is split into two HALF-bit operands and is
//   offered on a valid/ready handshake.
//   Pattern modes: 0 thermometer walk, 1 alternating all-ones/all-zeros,
//   2 32-bit Galois LFSR, 3 constant zero.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request, sampled only in IDLE
//   mode       in   [1:0] pattern mode, latched when start is taken
//   out_valid  out  op_a/op_b hold a flit
//   out_ready  in   consumer accepts the flit when out_valid & out_ready
//   op_a       out  [HALF-1:0] pattern[HALF-1:0]
//   op_b       out  [HALF-1:0] pattern[DATA_W-1:HALF]
//   last       out  final flit of the current packet
//   busy       out  run in progress (SEND or GAP)
//   done       out  one-cycle pulse at end of run
//   tog_cnt    out  [31:0] accumulated operand toggles (only with the macro)
//
// Build option
//   CHAR_TOGGLE_CNT_EN : adds the tog_cnt port and its popcount accumulator.
//
// States
//   state  | meaning
//   S_IDLE | waiting for start
//   S_SEND | presenting flits of the current packet
//   S_GAP  | idle cycles after a packet, operands held
//   S_DONE | one-cycle end-of-run pulse
module char_pattern_gen #(
  parameter int          DATA_W    = 62,
  parameter int          STEP      = 4,
  parameter int          PAYLOAD   = 20,
  parameter int          GAP       = 7,
  parameter int          NUM_PKTS  = 10,
  parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W/2-1:0]   op_a,
  output logic [DATA_W/2-1:0]   op_b,
  output logic                  last,
  output logic                  busy,
`ifdef CHAR_TOGGLE_CNT_EN
  output logic                  done,
  output logic [31:0]           tog_cnt
`else
  output logic                  done
`endif
);

  localparam int HALF = DATA_W / 2;
  localparam int CW   = $clog2(DATA_W + STEP + 1);
  localparam int FW   = (PAYLOAD  > 1) ? $clog2(PAYLOAD)  : 1;
  localparam int GW   = (GAP      > 1) ? $clog2(GAP)      : 1;
  localparam int PW   = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;

  localparam logic [FW-1:0]     FLIT_LOAD = FW'(PAYLOAD - 1);
  localparam logic [GW-1:0]     GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [PW-1:0]     PKT_LOAD  = PW'(NUM_PKTS - 1);
  localparam logic [DATA_W-1:0] ONES      = '1;
  localparam logic [CW-1:0]     STEP_C    = CW'(STEP);
  localparam logic [CW-1:0]     WIDTH_C   = CW'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [FW-1:0]       flit_left;
  logic [GW-1:0]       gap_left;
  logic [PW-1:0]       pkt_left;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   pattern;
  logic [31:0]         lfsr;
  logic [CW-1:0]       th_c;
  logic                th_drain;

  logic                start_take, accept, last_acc, gap_end, new_pkt, advance, restart;
  logic [1:0]          gen_mode;
  logic [31:0]         lfsr_nx;
  logic [CW-1:0]       th_c_in, th_c_nx;
  logic                th_d_in, th_d_nx;
  logic [DATA_W-1:0]   th_pat, pat_nx;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    // Galois form of x^32 + x^22 + x^2 + x + 1
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = v[i[4:0]];
    return r;
  endfunction

  assign start_take = (state == S_IDLE) && start;
  assign accept     = (state == S_SEND) && out_ready;
  assign last_acc   = accept && (flit_left == '0);
  assign gap_end    = (state == S_GAP) && (gap_left == '0);
  // With no gap the next packet begins on the edge that takes the last flit.
  assign new_pkt    = ((GAP > 0) ? gap_end : last_acc) && (pkt_left != '0);
  // The last flit of a packet holds through the gap; its successor is
  // produced when the next packet begins.
  assign advance    = (accept && (flit_left != '0)) || new_pkt;
  assign restart    = start_take || new_pkt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        last      = (flit_left == '0);
        if (last_acc) begin
          if (GAP > 0)              state_nx = S_GAP;
          else if (pkt_left == '0)  state_nx = S_DONE;
          else                      state_nx = S_SEND;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (gap_left == '0) state_nx = (pkt_left == '0) ? S_DONE : S_SEND;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Thermometer walk: FILL grows ones from the MSB end; once another step
  // would overflow, DRAIN shrinks ones from the LSB end down to zero, emits
  // one extra all-zero flit and refills.
  always_comb begin
    th_c_in = restart ? '0 : th_c;
    th_d_in = restart ? 1'b0 : th_drain;
    th_c_nx = th_c_in;
    th_d_nx = th_d_in;
    th_pat  = '0;
    if (!th_d_in) begin
      if (th_c_in + STEP_C > WIDTH_C) begin
        th_d_nx = 1'b1;
        th_pat  = ~(ONES << th_c_in);
      end else begin
        th_c_nx = th_c_in + STEP_C;
        th_pat  = ~(ONES >> th_c_nx);
      end
    end else if (th_c_in == '0) begin
      th_d_nx = 1'b0;
      th_pat  = '0;
    end else begin
      th_c_nx = (th_c_in > STEP_C) ? th_c_in - STEP_C : '0;
      th_pat  = ~(ONES << th_c_nx);
    end
  end

  always_comb begin
    gen_mode = start_take ? mode : mode_q;
    lfsr_nx  = start_take ? LFSR_SEED : lfsr_step(lfsr);
    pat_nx   = '0;
    case (gen_mode)
      2'd0:    pat_nx = th_pat;
      2'd1:    pat_nx = start_take ? ONES : ~pattern;
      2'd2:    pat_nx = replicate(lfsr_nx);
      default: pat_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= '0;
      pattern   <= '0;
      lfsr      <= LFSR_SEED;
      th_c      <= '0;
      th_drain  <= 1'b0;
      flit_left <= '0;
      gap_left  <= '0;
      pkt_left  <= '0;
    end else begin
      if (start_take) begin
        mode_q    <= mode;
        pkt_left  <= PKT_LOAD;
        flit_left <= FLIT_LOAD;
      end
      if (start_take || advance) begin
        pattern  <= pat_nx;
        lfsr     <= lfsr_nx;
        th_c     <= th_c_nx;
        th_drain <= th_d_nx;
      end
      if (new_pkt) begin
        pkt_left  <= pkt_left - PW'(1);
        flit_left <= FLIT_LOAD;
      end else if (accept && (flit_left != '0)) begin
        flit_left <= flit_left - FW'(1);
      end
      if (last_acc && (GAP > 0))                      gap_left <= GAP_LOAD;
      else if ((state == S_GAP) && (gap_left != '0))  gap_left <= gap_left - GW'(1);
    end
  end

  assign op_a = pattern[HALF-1:0];
  assign op_b = pattern[DATA_W-1:HALF];

`ifdef CHAR_TOGGLE_CNT_EN
  logic [DATA_W-1:0] prev_pat;
  logic [31:0]       pop;
  logic [32:0]       tog_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_W; i++) pop = pop + 32'(pattern[i] ^ prev_pat[i]);
    tog_sum = {1'b0, tog_cnt} + {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pat <= '0;
      tog_cnt  <= '0;
    end else if (start_take) begin
      prev_pat <= '0;
      tog_cnt  <= '0;
    end else if (accept) begin
      prev_pat <= pattern;
      tog_cnt  <= tog_sum[32] ? 32'hFFFF_FFFF : tog_sum[31:0];
    end
  end
`endif

endmodule
